// File: rtl/scom_pkg.sv
// Shared constants, state encoding and checksum helper for the scom command decoder.
package scom_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] HDR_WR  = 8'hAA;
  localparam logic [BYTE_W-1:0] HDR_RD  = 8'hAB;
  localparam logic [BYTE_W-1:0] ACK_OK  = 8'h55;
  localparam logic [BYTE_W-1:0] ACK_ERR = 8'hEE;

  typedef enum logic [2:0] {
    S_HDR,
    S_ADDR,
    S_DATA,
    S_CSUM,
    S_EXEC,
    S_RDWAIT,
    S_RESP
  } state_e;

  function automatic logic [BYTE_W-1:0] frame_sum(input logic [BYTE_W-1:0] hdr,
                                                  input logic [BYTE_W-1:0] addr,
                                                  input logic [BYTE_W-1:0] data);
    return BYTE_W'(hdr + addr + data);
  endfunction

endpackage

// File: rtl/scom_cmd_decoder_if.sv
// Command FIFO, register and response FIFO signals of the scom decoder.
// SCOM_READBACK_EN adds the register read strobe and read data.
interface scom_cmd_decoder_if;
  import scom_pkg::*;

  logic              cmd_empty;
  logic [BYTE_W-1:0] cmd_q;
  logic              cmd_rd;
  logic              reg_wr;
  logic [BYTE_W-1:0] reg_addr;
  logic [BYTE_W-1:0] reg_wdata;
  logic              resp_full;
  logic              resp_wr;
  logic [BYTE_W-1:0] resp_data;
  logic [BYTE_W-1:0] err_cnt;
`ifdef SCOM_READBACK_EN
  logic              reg_rd;
  logic [BYTE_W-1:0] reg_rdata;
`endif

  modport master (
    input  cmd_empty, cmd_q, resp_full,
`ifdef SCOM_READBACK_EN
    input  reg_rdata,
    output reg_rd,
`endif
    output cmd_rd, reg_wr, reg_addr, reg_wdata, resp_wr, resp_data, err_cnt
  );

  modport slave (
    output cmd_empty, cmd_q, resp_full,
`ifdef SCOM_READBACK_EN
    output reg_rdata,
    input  reg_rd,
`endif
    input  cmd_rd, reg_wr, reg_addr, reg_wdata, resp_wr, resp_data, err_cnt
  );

endinterface

// File: rtl/scom_byte_fetch.sv
// Non-showahead FIFO reader: one read in flight at a time, byte presented the cycle after cmd_rd.
module scom_byte_fetch
  import scom_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic              cmd_empty,
  input  logic [BYTE_W-1:0] cmd_q,
  output logic              cmd_rd,
  output logic              byte_vld,
  output logic [BYTE_W-1:0] byte_q,
  output logic              outstanding
);

  // The byte_vld cycle also blocks a new read so the parser can change state first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_rd   <= 1'b0;
      byte_vld <= 1'b0;
    end else begin
      cmd_rd   <= fetch_en && !cmd_empty && !cmd_rd && !byte_vld;
      byte_vld <= cmd_rd;
    end
  end

  assign byte_q      = cmd_q;
  assign outstanding = cmd_rd;

endmodule

// File: rtl/scom_cmd_decoder.sv
// Parses 4-byte scom command frames into register strobes and 1-byte acknowledges.
// Optional SCOM_READBACK_EN accepts 0xAB read frames answered with register read data.
module scom_cmd_decoder
  import scom_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 2500,
  parameter int unsigned TO_W        = 12
) (
  input logic                clk,
  input logic                reset,
  scom_cmd_decoder_if.master bus
);

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC - 1);

  state_e            state, state_nxt;
  logic [BYTE_W-1:0] addr_tmp, addr_nxt;
  logic [BYTE_W-1:0] data_tmp, data_nxt;
  logic              frame_ok, ok_nxt;
  logic              rd_frame, rd_frame_nxt;
  logic [TO_W-1:0]   to_cnt, to_cnt_nxt;

  logic              reg_wr, reg_wr_nxt;
  logic [BYTE_W-1:0] reg_addr, reg_addr_nxt;
  logic [BYTE_W-1:0] reg_wdata, reg_wdata_nxt;
  logic [BYTE_W-1:0] resp_data, resp_data_nxt;
  logic [BYTE_W-1:0] err_cnt, err_cnt_nxt;
`ifdef SCOM_READBACK_EN
  logic              reg_rd, reg_rd_nxt;
`endif

  logic              err_inc;
  logic              resp_wr_c;
  logic              counting;
  logic              timeout;
  logic              fetch_en;
  logic              byte_vld;
  logic              outstanding;
  logic [BYTE_W-1:0] byte_q;

  assign counting = (state == S_ADDR) || (state == S_DATA) || (state == S_CSUM);
  assign fetch_en = (state == S_HDR) || counting;
  // A read in flight is always consumed before the timeout may drop the frame.
  assign timeout  = counting && (to_cnt == TO_MAX) && !outstanding && !byte_vld;

  scom_byte_fetch u_fetch (
    .clk         (clk),
    .reset       (reset),
    .fetch_en    (fetch_en),
    .cmd_empty   (bus.cmd_empty),
    .cmd_q       (bus.cmd_q),
    .cmd_rd      (bus.cmd_rd),
    .byte_vld    (byte_vld),
    .byte_q      (byte_q),
    .outstanding (outstanding)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_HDR;
      addr_tmp  <= '0;
      data_tmp  <= '0;
      frame_ok  <= 1'b0;
      rd_frame  <= 1'b0;
      to_cnt    <= '0;
      reg_wr    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      resp_data <= '0;
      err_cnt   <= '0;
`ifdef SCOM_READBACK_EN
      reg_rd    <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      addr_tmp  <= addr_nxt;
      data_tmp  <= data_nxt;
      frame_ok  <= ok_nxt;
      rd_frame  <= rd_frame_nxt;
      to_cnt    <= to_cnt_nxt;
      reg_wr    <= reg_wr_nxt;
      reg_addr  <= reg_addr_nxt;
      reg_wdata <= reg_wdata_nxt;
      resp_data <= resp_data_nxt;
      err_cnt   <= err_cnt_nxt;
`ifdef SCOM_READBACK_EN
      reg_rd    <= reg_rd_nxt;
`endif
    end
  end

  // Strobes and register outputs are loaded on the CSUM byte so they are live during S_EXEC.
  always_comb begin
    state_nxt     = state;
    addr_nxt      = addr_tmp;
    data_nxt      = data_tmp;
    ok_nxt        = frame_ok;
    rd_frame_nxt  = rd_frame;
    reg_wr_nxt    = 1'b0;
    reg_addr_nxt  = reg_addr;
    reg_wdata_nxt = reg_wdata;
    resp_data_nxt = resp_data;
    err_inc       = 1'b0;
    resp_wr_c     = 1'b0;
`ifdef SCOM_READBACK_EN
    reg_rd_nxt    = 1'b0;
`endif

    case (state)
      S_HDR: begin
        if (byte_vld) begin
          if (byte_q == HDR_WR) begin
            rd_frame_nxt = 1'b0;
            state_nxt    = S_ADDR;
          end
`ifdef SCOM_READBACK_EN
          else if (byte_q == HDR_RD) begin
            rd_frame_nxt = 1'b1;
            state_nxt    = S_ADDR;
          end
`endif
        end
      end
      S_ADDR: begin
        if (byte_vld) begin
          addr_nxt  = byte_q;
          state_nxt = S_DATA;
        end else if (timeout) begin
          err_inc   = 1'b1;
          state_nxt = S_HDR;
        end
      end
      S_DATA: begin
        if (byte_vld) begin
          data_nxt  = byte_q;
          state_nxt = S_CSUM;
        end else if (timeout) begin
          err_inc   = 1'b1;
          state_nxt = S_HDR;
        end
      end
      S_CSUM: begin
        if (byte_vld) begin
          ok_nxt    = (byte_q == frame_sum(rd_frame ? HDR_RD : HDR_WR, addr_tmp, data_tmp));
          state_nxt = S_EXEC;
          if (ok_nxt) begin
            reg_addr_nxt  = addr_tmp;
            resp_data_nxt = ACK_OK;
            if (!rd_frame) begin
              reg_wr_nxt    = 1'b1;
              reg_wdata_nxt = data_tmp;
            end
`ifdef SCOM_READBACK_EN
            else begin
              reg_rd_nxt = 1'b1;
            end
`endif
          end else begin
            resp_data_nxt = ACK_ERR;
          end
        end else if (timeout) begin
          err_inc   = 1'b1;
          state_nxt = S_HDR;
        end
      end
      S_EXEC: begin
        err_inc   = !frame_ok;
        state_nxt = (frame_ok && rd_frame) ? S_RDWAIT : S_RESP;
      end
`ifdef SCOM_READBACK_EN
      S_RDWAIT: begin
        resp_data_nxt = bus.reg_rdata;
        state_nxt     = S_RESP;
      end
`endif
      S_RESP: begin
        if (!bus.resp_full) begin
          resp_wr_c = 1'b1;
          state_nxt = S_HDR;
        end
      end
      default: state_nxt = S_HDR;
    endcase

    err_cnt_nxt = (err_inc && (err_cnt != 8'hFF)) ? BYTE_W'(err_cnt + 8'd1) : err_cnt;

    if (!counting || byte_vld || (state_nxt != state)) begin
      to_cnt_nxt = '0;
    end else if (to_cnt != TO_MAX) begin
      to_cnt_nxt = to_cnt + TO_W'(1);
    end else begin
      to_cnt_nxt = to_cnt;
    end
  end

  assign bus.reg_wr    = reg_wr;
  assign bus.reg_addr  = reg_addr;
  assign bus.reg_wdata = reg_wdata;
  assign bus.resp_wr   = resp_wr_c;
  assign bus.resp_data = resp_data;
  assign bus.err_cnt   = err_cnt;
`ifdef SCOM_READBACK_EN
  assign bus.reg_rd    = reg_rd;
`endif

endmodule
